// File: rtl/dual_issue_scheduler.sv
// Two-lane issue controller: decides per cycle whether the fetched pair dual-issues,
// single-issues, stalls on a pending load, or is squashed after a taken branch.
module dual_issue_scheduler #(
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int NREGS        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] instruction0,
  input  logic [31:0] instruction1,
  input  logic        branch_taken,
  output logic        datapath_1_enable,
  output logic        datapath_2_enable,
  output logic [31:0] issue_ins0,
  output logic [31:0] issue_ins1,
  output logic        freeze1,
  output logic        freeze2,
  output logic [1:0]  pc_advance,
  output logic [1:0]  dbg_state
);

  localparam int RW = $clog2(NREGS);
  localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam int FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  typedef struct packed {
    logic          rd_w;
    logic          rs1_r;
    logic          rs2_r;
    logic          ctrl;
    logic          mem;
    logic          load;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } dec_t;

  // Register-use flags are cleared for x0 so x0 can never create a hazard.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d     = '0;
    d.rd  = ins[7 +: RW];
    d.rs1 = ins[15 +: RW];
    d.rs2 = ins[20 +: RW];
    case (ins[6:0])
      OP_LUI, OP_AUIPC: d.rd_w = 1'b1;
      OP_JAL:  begin d.rd_w = 1'b1; d.ctrl = 1'b1; end
      OP_JALR: begin d.rd_w = 1'b1; d.rs1_r = 1'b1; d.ctrl = 1'b1; end
      OP_BR:   begin d.rs1_r = 1'b1; d.rs2_r = 1'b1; d.ctrl = 1'b1; end
      OP_LD:   begin d.rd_w = 1'b1; d.rs1_r = 1'b1; d.mem = 1'b1; d.load = 1'b1; end
      OP_ST:   begin d.rs1_r = 1'b1; d.rs2_r = 1'b1; d.mem = 1'b1; end
      OP_IMM:  begin d.rd_w = 1'b1; d.rs1_r = 1'b1; end
      OP_REG:  begin d.rd_w = 1'b1; d.rs1_r = 1'b1; d.rs2_r = 1'b1; end
      default: ;
    endcase
    if (d.rd == '0)  d.rd_w  = 1'b0;
    if (d.rs1 == '0) d.rs1_r = 1'b0;
    if (d.rs2 == '0) d.rs2_r = 1'b0;
    return d;
  endfunction

  function automatic logic reads(input dec_t d, input logic [RW-1:0] r);
    return (d.rs1_r && (d.rs1 == r)) || (d.rs2_r && (d.rs2 == r));
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] busy_q, busy_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          en1_d, en2_d, f1_d, f2_d, load_issue;
  logic [1:0]    adv_d;
  logic [31:0]   ins0_d, ins1_d;
  dec_t          da, db;
  logic          a_busy, b_busy, dual_ok;

  assign da     = decode(instruction0);
  assign db     = decode(instruction1);
  assign a_busy = (cnt_q != '0) && reads(da, busy_q);
  assign b_busy = (cnt_q != '0) && reads(db, busy_q);
  // Lane 2 has no memory port and lane 1 must not be a redirect for B to go alongside.
  assign dual_ok = !(da.rd_w && reads(db, da.rd)) &&
                   !(da.rd_w && db.rd_w && (da.rd == db.rd)) &&
                   !da.ctrl && !db.mem && !b_busy;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    en1_d      = 1'b0;
    en2_d      = 1'b0;
    f1_d       = 1'b0;
    f2_d       = 1'b0;
    adv_d      = 2'd0;
    ins0_d     = NOP;
    ins1_d     = NOP;
    load_issue = 1'b0;
    if (branch_taken) begin
      state_d = FLUSH;
      flush_d = FW'(FLUSH_CYCLES - 1);
    end else if ((state_q == FLUSH) && (flush_q != '0)) begin
      flush_d = flush_q - 1'b1;
    end else begin
      // STALL re-evaluates every cycle; the held pair keeps it stalled until the counter drains.
      state_d = RUN;
      if (fetch_valid) begin
        if (a_busy) begin
          state_d = STALL;
          f1_d    = 1'b1;
        end else if (dual_ok) begin
          en1_d      = 1'b1;
          en2_d      = 1'b1;
          adv_d      = 2'd2;
          ins0_d     = instruction0;
          ins1_d     = instruction1;
          load_issue = da.load;
        end else begin
          en1_d      = 1'b1;
          f2_d       = 1'b1;
          adv_d      = 2'd1;
          ins0_d     = instruction0;
          load_issue = da.load;
        end
      end
    end
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (load_issue) begin
      busy_d = da.rd;
      cnt_d  = CW'(LOAD_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= RUN;
      flush_q           <= '0;
      cnt_q             <= '0;
      busy_q            <= '0;
      datapath_1_enable <= 1'b0;
      datapath_2_enable <= 1'b0;
      freeze1           <= 1'b0;
      freeze2           <= 1'b0;
      pc_advance        <= 2'd0;
      issue_ins0        <= NOP;
      issue_ins1        <= NOP;
    end else begin
      state_q           <= state_d;
      flush_q           <= flush_d;
      cnt_q             <= cnt_d;
      busy_q            <= busy_d;
      datapath_1_enable <= en1_d;
      datapath_2_enable <= en2_d;
      freeze1           <= f1_d;
      freeze2           <= f2_d;
      pc_advance        <= adv_d;
      issue_ins0        <= ins0_d;
      issue_ins1        <= ins1_d;
    end
  end

  assign dbg_state = state_q;

endmodule
